seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 85 ++++++++
 tb/tb_seven_seg_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed 8-digit seven-segment scanner: one digit driven per TICK_DIV-cycle slot.
// Optional anti-ghosting blanking at the start of each slot when SEVEN_SEG_BLANK_EN is defined.
module seven_seg_scanner #(
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic [63:0] ss_in,
    output logic [7:0]  seg,
    output logic [7:0]  dig_n,
    output logic        frame_start
);

    localparam int                 CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
`ifdef SEVEN_SEG_BLANK_EN
    localparam logic [CNT_W-1:0]   BLANK_LIM = CNT_W'(BLANK_CYCLES);
`endif

    if (TICK_DIV < 2 || TICK_DIV > 65535 || BLANK_CYCLES < 1 || BLANK_CYCLES >= TICK_DIV) begin : g_param_check
        $error("seven_seg_scanner: illegal TICK_DIV/BLANK_CYCLES");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       dig_n_q, dig_n_d;
    logic             frame_start_q, frame_start_d;

    // Parked state (last count of digit 7) makes the first enabled edge land on digit 0, count 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q         <= CNT_LAST;
            idx_q         <= 3'd7;
            seg_q         <= 8'h00;
            dig_n_q       <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            dig_n_q       <= dig_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        cnt_d = CNT_LAST;
        idx_d = 3'd7;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    // Outputs are computed from the next state so they are registered without extra latency.
    always_comb begin
        seg_d         = 8'h00;
        dig_n_d       = 8'hFF;
        frame_start_d = 1'b0;
        if (enable) begin
            seg_d         = ss_in[{idx_d, 3'b000} +: 8];
            dig_n_d       = ~(8'h01 << idx_d);
            frame_start_d = (idx_d == 3'd0) && (cnt_d == '0);
`ifdef SEVEN_SEG_BLANK_EN
            if (cnt_d < BLANK_LIM) begin
                seg_d   = 8'h00;
                dig_n_d = 8'hFF;
            end
`endif
        end
    end

    assign seg         = seg_q;
    assign dig_n       = dig_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (TICK_DIV=4, BLANK_CYCLES=1); honours SEVEN_SEG_BLANK_EN.
module tb_seven_seg_scanner;

    localparam int TICK    = 4;
    localparam int BLANK_N = 1;
`ifdef SEVEN_SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [63:0] ss_in;
    logic [7:0]  seg;
    logic [7:0]  dig_n;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    seven_seg_scanner #(.TICK_DIV(TICK), .BLANK_CYCLES(BLANK_N)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .enable      (enable),
        .ss_in       (ss_in),
        .seg         (seg),
        .dig_n       (dig_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Model: time-based view -- m_t counts enabled edges since the scan (re)started.
    bit         m_parked = 1'b1;
    int         m_t      = 0;
    int         m_digit  = 0;
    logic [7:0] m_seg    = 8'h00;
    logic [7:0] m_dig    = 8'hFF;
    logic       m_fs     = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_parked = 1'b1;
            m_seg    = 8'h00;
            m_dig    = 8'hFF;
            m_fs     = 1'b0;
        end else if (enable) begin
            m_t      = m_parked ? 0 : m_t + 1;
            m_parked = 1'b0;
            m_digit  = (m_t / TICK) % 8;
            m_seg    = ss_in[m_digit*8 +: 8];
            m_dig    = ~(8'd1 << m_digit);
            m_fs     = ((m_t % (8*TICK)) == 0);
            if (BLANK && ((m_t % TICK) < BLANK_N)) begin
                m_seg = 8'h00;
                m_dig = 8'hFF;
            end
        end else begin
            m_parked = 1'b1;
            m_seg    = 8'h00;
            m_dig    = 8'hFF;
            m_fs     = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (seg !== m_seg) begin
                n_bad++;
                $display("FAIL model_seg t=%0t got=%02h exp=%02h", $time, seg, m_seg);
            end
            n_cmp++;
            if (dig_n !== m_dig) begin
                n_bad++;
                $display("FAIL model_dig_n t=%0t got=%02h exp=%02h", $time, dig_n, m_dig);
            end
            n_cmp++;
            if (frame_start !== m_fs) begin
                n_bad++;
                $display("FAIL model_frame_start t=%0t got=%0b exp=%0b", $time, frame_start, m_fs);
            end
            n_cmp++;
            if ($countones(~dig_n) > 1) begin
                n_bad++;
                $display("FAIL one_hot t=%0t dig_n=%02h exp=at most one low bit", $time, dig_n);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%02h exp=%02h", name, got, exp);
        end else begin
            $display("ok   %s = %02h", name, got);
        end
    endtask

    task automatic check3(input string name, input logic [7:0] s, input logic [7:0] d, input logic f);
        check({name, ".seg"}, seg, s);
        check({name, ".dig_n"}, dig_n, d);
        check({name, ".frame_start"}, {7'd0, frame_start}, {7'd0, f});
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Slot-0 expectation: blanked when blanking is compiled in.
    function automatic logic [7:0] s0(input logic [7:0] v);
        return BLANK ? 8'h00 : v;
    endfunction
    function automatic logic [7:0] d0(input logic [7:0] v);
        return BLANK ? 8'hFF : v;
    endfunction

    initial begin
        nrst   = 1'b0;
        enable = 1'b1;
        ss_in  = 64'h07_7D_6D_66_4F_5B_06_3F;
        wait_edges(2);
        check_en = 1'b1;
        check3("reset", 8'h00, 8'hFF, 1'b0);
        nrst = 1'b1;

        // Basic scan
        wait_edges(1);
        check3("first_edge", s0(8'h3F), d0(8'hFE), 1'b1);
        wait_edges(1);
        check3("edge1", 8'h3F, 8'hFE, 1'b0);
        wait_edges(3);
        check3("slot1_start", s0(8'h06), d0(8'hFD), 1'b0);
        wait_edges(28);
        check3("frame2_start", s0(8'h3F), d0(8'hFE), 1'b1);

        // Mid-slot data change in slot 2
        wait_edges(9);
        check3("slot2_cnt1", 8'h5B, 8'hFB, 1'b0);
        ss_in[23:16] = 8'h4F;
        wait_edges(1);
        check3("slot2_changed", 8'h4F, 8'hFB, 1'b0);

        // Disable mid-frame during slot 5
        wait_edges(11);
        check3("slot5_cnt1", 8'h6D, 8'hDF, 1'b0);
        enable = 1'b0;
        wait_edges(1);
        check3("disabled", 8'h00, 8'hFF, 1'b0);
        wait_edges(3);
        enable = 1'b1;
        wait_edges(1);
        check3("reenabled", s0(8'h3F), d0(8'hFE), 1'b1);

        // Asynchronous reset during slot 3
        wait_edges(13);
        check3("slot3_cnt1", 8'h4F, 8'hF7, 1'b0);
        #2 nrst = 1'b0;
        #1;
        check3("async_reset", 8'h00, 8'hFF, 1'b0);
        wait_edges(2);
        nrst = 1'b1;
        wait_edges(1);
        check3("after_reset", s0(8'h3F), d0(8'hFE), 1'b1);

        // Free run with changing data and a short disable; model checks every cycle
        for (int i = 0; i < 40; i++) begin
            ss_in[(i % 8)*8 +: 8] = 8'(i * 37 + 5);
            enable = (i != 20);
            wait_edges(1);
        end
        enable = 1'b1;
        wait_edges(40);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
